// File: rtl/mux41x16_arbiter_if.sv
// Requester/downstream bundle for the four-way round-robin mux arbiter.
// The master side is the requester/sink environment and the slave side is the arbiter.
interface mux41x16_arbiter_if;
    logic [3:0]  req;
    logic [15:0] arg0;
    logic [15:0] arg1;
    logic [15:0] arg2;
    logic [15:0] arg3;
    logic        dout_ready;
    logic [3:0]  gnt;
    logic [1:0]  cntrl;
    logic [15:0] dout;
    logic        dout_valid;
    logic [3:0]  ack;

    modport master (
        output req, arg0, arg1, arg2, arg3, dout_ready,
        input  gnt, cntrl, dout, dout_valid, ack
    );

    modport slave (
        input  req, arg0, arg1, arg2, arg3, dout_ready,
        output gnt, cntrl, dout, dout_valid, ack
    );
endinterface

// File: rtl/mux41x16_arbiter.sv
// Round-robin burst arbiter that owns the select of a shared 4:1 x16 mux.
// The grant is held for up to MAX_BEATS accepted words, and then it rotates.
module mux41x16 (
    input  logic [15:0] arg0,
    input  logic [15:0] arg1,
    input  logic [15:0] arg2,
    input  logic [15:0] arg3,
    input  logic [1:0]  cntrl,
    output logic [15:0] dout
);
    always_comb begin
        case (cntrl)
            2'd0:    dout = arg0;
            2'd1:    dout = arg1;
            2'd2:    dout = arg2;
            default: dout = arg3;
        endcase
    end
endmodule

module mux41x16_arbiter #(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    mux41x16_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       cntrl_q, cntrl_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [1:0]       last_q, last_d;

    logic       dout_valid, xfer, rel_a, rel_b, rel;
    logic [1:0] base, idx, win;
    logic [3:0] cand;
    logic       found;

    assign dout_valid = (state_q == GRANT) & bus.req[cntrl_q];
    assign xfer       = dout_valid & bus.dout_ready;
    assign rel_a      = (state_q == GRANT) & ~bus.req[cntrl_q];
    assign rel_b      = xfer & (beat_q == LAST_BEAT);
    assign rel        = rel_a | rel_b;

    // The scan starts just past the previous owner. A burst-end owner comes up last, at +4.
    always_comb begin
        base  = (state_q == IDLE) ? last_q : cntrl_q;
        cand  = rel_a ? (bus.req & ~gnt_q) : bus.req;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cntrl_d = cntrl_q;
        beat_d  = beat_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (found) begin
                    state_d = GRANT;
                    cntrl_d = win;
                end
            end
            GRANT: begin
                if (rel) begin
                    last_d = cntrl_q;
                    beat_d = '0;
                    if (found) begin
                        cntrl_d = win;
                    end else begin
                        state_d = IDLE;
                        cntrl_d = '0;
                    end
                end else if (xfer) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cntrl_d = '0;
                beat_d  = '0;
            end
        endcase
        gnt_d = (state_d == GRANT) ? (4'b0001 << cntrl_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            cntrl_q <= 2'd0;
            beat_q  <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cntrl_q <= cntrl_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.cntrl      = cntrl_q;
    assign bus.dout_valid = dout_valid;
    assign bus.ack        = gnt_q & {4{xfer}};

    mux41x16 u_mux (
        .arg0  (bus.arg0),
        .arg1  (bus.arg1),
        .arg2  (bus.arg2),
        .arg3  (bus.arg3),
        .cntrl (cntrl_q),
        .dout  (bus.dout)
    );
endmodule

// File: tb/tb_mux41x16_arbiter.sv
// Bench for mux41x16_arbiter. It runs directed scenarios and then random traffic against a small
// owner/beat-count reference model.
module tb_mux41x16_arbiter;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Reference model state. own = -1 means idle.
    int own   = -1;
    int beats = 0;
    int last  = 3;

    logic [15:0] arg [4];
    logic [3:0]  obs_ack;
    logic [3:0]  exp_ack;

    mux41x16_arbiter_if bus();

    mux41x16_arbiter #(.MAX_BEATS(MAXB)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 1; k <= 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs and check the outputs against the model.
    // Then advance the model across the clock edge.
    task automatic cyc(input logic r_rst, input logic [3:0] r_req, input logic rdy);
        logic        ev;
        logic [3:0]  egnt;
        logic [3:0]  eack;
        logic [3:0]  m;
        rst            = r_rst;
        bus.req        = r_req;
        bus.dout_ready = rdy;
        bus.arg0       = arg[0];
        bus.arg1       = arg[1];
        bus.arg2       = arg[2];
        bus.arg3       = arg[3];
        #1;
        ev   = (own >= 0) && r_req[own];
        egnt = (own >= 0) ? 4'(1 << own) : 4'b0000;
        eack = (ev && rdy) ? egnt : 4'b0000;
        chk("gnt",   32'(bus.gnt),        32'(egnt));
        chk("cntrl", 32'(bus.cntrl),      32'((own >= 0) ? own : 0));
        chk("valid", 32'(bus.dout_valid), 32'(ev));
        chk("ack",   32'(bus.ack),        32'(eack));
        if (ev) chk("dout", 32'(bus.dout), 32'(arg[own]));
        obs_ack = bus.ack;
        exp_ack = eack;
        if (r_rst) begin
            own = -1; beats = 0; last = 3;
        end else if (own < 0) begin
            if (r_req != 0) begin own = pick(r_req, last); beats = 0; end
        end else if (!r_req[own]) begin
            m    = r_req;
            m[own] = 1'b0;
            last = own;
            own  = pick(m, own);
            beats = 0;
        end else if (rdy) begin
            beats++;
            if (beats == MAXB) begin
                last  = own;
                own   = pick(r_req, own);
                beats = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int       nack;
        logic [3:0] pend;
        logic     rdy;
        arg[0] = 16'h1111; arg[1] = 16'h2222; arg[2] = 16'hBEEF; arg[3] = 16'h4444;
        rst = 1'b1;
        bus.req = 4'b1111; bus.dout_ready = 1'b1;
        bus.arg0 = arg[0]; bus.arg1 = arg[1]; bus.arg2 = arg[2]; bus.arg3 = arg[3];
        @(posedge clk); #1;

        // 1: reset held with all requests. The grant goes to req0 after release.
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1111, 1'b1);
        cyc(1'b0, 4'b1111, 1'b1);
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        cyc(1'b1, 4'b0000, 1'b1);

        // 2: single requester. Acks are continuous across the forced re-grant.
        nack = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 4'b0100, 1'b1);
            if (obs_ack[2]) nack++;
        end
        chk("t2_acks", 32'(nack), 32'd11);
        cyc(1'b1, 4'b0000, 1'b1);

        // 3: all requesting. 16 back-to-back acks rotate through 0, 1, 2, 3.
        nack = 0;
        for (int i = 0; i < 17; i++) begin
            cyc(1'b0, 4'b1111, 1'b1);
            if (obs_ack != 0) nack++;
        end
        chk("t3_acks", 32'(nack), 32'd16);
        chk("t3_gnt", 32'(bus.gnt), 32'h1);
        cyc(1'b1, 4'b0000, 1'b1);

        // 4: backpressure while owner 1 holds the grant.
        cyc(1'b0, 4'b0010, 1'b1);
        cyc(1'b0, 4'b0010, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'b0010, 1'b0);
        chk("t4_hold", 32'(bus.gnt), 32'h2);
        for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1010, 1'b1);
        cyc(1'b1, 4'b0000, 1'b1);

        // 5: owner 0 drops its request mid-burst. Requester 3 takes the grant.
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1001, 1'b1);
        cyc(1'b0, 4'b1000, 1'b1);
        chk("t5_gnt", 32'(bus.gnt), 32'h8);
        chk("t5_cntrl", 32'(bus.cntrl), 32'd3);
        cyc(1'b1, 4'b0000, 1'b1);

        // 6: reset mid-burst. Priority restarts at req0.
        cyc(1'b0, 4'b0100, 1'b1);
        cyc(1'b0, 4'b0100, 1'b1);
        cyc(1'b1, 4'b0100, 1'b1);
        chk("t6_gnt", 32'(bus.gnt), 32'h0);
        cyc(1'b0, 4'b1111, 1'b1);
        chk("t6_regnt", 32'(bus.gnt), 32'h1);

        // Random traffic. Data stays stable until acked, and requests sometimes drop early.
        pend = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(99) < 3) pend[i] = 1'b0;
                end else if ($urandom_range(99) < 40) begin
                    pend[i] = 1'b1;
                    arg[i]  = 16'($urandom);
                end
            end
            rdy = ($urandom_range(99) < 70);
            cyc(($urandom_range(199) == 0), pend, rdy);
            pend = pend & ~exp_ack;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
